// File: rtl/ode_ctrl_pkg.sv
// Shared control definitions for the ODE accelerator: arbiter FSM states
// and default word/watchdog sizes.
package ode_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } arb_state_t;

   localparam int DEF_WORD_SIZE      = 16;
   localparam int DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or above the
// pointer, wrapping modulo NUM_REQ; returns one-hot and binary index.
module rr_picker
   import ode_ctrl_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] onehot,
   output logic [IDX_W-1:0]   idx
);

   int pos;

   // Scan from the farthest offset down so the closest hit to ptr is written last.
   always_comb begin
      onehot = '0;
      idx    = '0;
      pos    = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         pos = int'(ptr) + i;
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         if (req[pos]) begin
            onehot      = '0;
            onehot[pos] = 1'b1;
            idx         = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one multiplier among NUM_REQ requesters.
// Optional watchdog on the multiplier wait: define MULT_ARB_TIMEOUT_EN.
module mult_arbiter
   import ode_ctrl_pkg::*;
#(
   parameter int WORD_SIZE      = DEF_WORD_SIZE,
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*WORD_SIZE-1:0]  op_a,
   input  logic [NUM_REQ*WORD_SIZE-1:0]  op_b,
   output logic [NUM_REQ-1:0]            grant,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [WORD_SIZE-1:0]          rsp_data,
   output logic                          rsp_overflow,
   output logic                          rsp_timeout,
   output logic                          busy,
   output logic                          mul_start,
   output logic [WORD_SIZE-1:0]          mul_a,
   output logic [WORD_SIZE-1:0]          mul_b,
   input  logic [WORD_SIZE-1:0]          mul_out,
   input  logic                          mul_overflow,
   input  logic                          mul_done,
   output arb_state_t                    dbg_state
);

   // Handshake: a requester holds req (and its operands) as a level until it
   // sees its own rsp_valid bit; grant marks the owner from START through RESP;
   // rsp_valid is a one-cycle completion pulse with no back-pressure.

   localparam int IDX_W = $clog2(NUM_REQ);

   arb_state_t           state, state_next;
   logic [IDX_W-1:0]     ptr;
   logic [IDX_W-1:0]     owner;
   logic [NUM_REQ-1:0]   pick_onehot;
   logic [IDX_W-1:0]     pick_idx;
   logic                 to_hit;
   logic                 timeout_r;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req    (req),
      .ptr    (ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx)
   );

`ifdef MULT_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt;

   // The last WAIT cycle is the one where the count is about to reach the limit.
   assign to_hit = (state == S_WAIT) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         to_cnt <= '0;
      end else if (state == S_START) begin
         to_cnt <= '0;
      end else if (state == S_WAIT && !to_hit) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (|req) state_next = S_START;
         S_START: state_next = S_WAIT;
         S_WAIT:  if (mul_done || to_hit) state_next = S_RESP;
         S_RESP:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Every output is a register; strobes are derived from the upcoming state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant        <= '0;
         rsp_valid    <= '0;
         rsp_data     <= '0;
         rsp_overflow <= 1'b0;
         timeout_r    <= 1'b0;
         busy         <= 1'b0;
         mul_start    <= 1'b0;
         mul_a        <= '0;
         mul_b        <= '0;
         ptr          <= '0;
         owner        <= '0;
      end else begin
         mul_start <= (state_next == S_START);
         busy      <= (state_next != S_IDLE);
         rsp_valid <= (state_next == S_RESP) ? grant : '0;
         case (state)
            S_IDLE: begin
               if (|req) begin
                  grant <= pick_onehot;
                  owner <= pick_idx;
                  mul_a <= op_a[int'(pick_idx)*WORD_SIZE +: WORD_SIZE];
                  mul_b <= op_b[int'(pick_idx)*WORD_SIZE +: WORD_SIZE];
               end
            end
            S_WAIT: begin
               // A done in the watchdog's final cycle takes precedence.
               if (mul_done) begin
                  rsp_data     <= mul_out;
                  rsp_overflow <= mul_overflow;
                  timeout_r    <= 1'b0;
               end else if (to_hit) begin
                  rsp_data     <= '0;
                  rsp_overflow <= 1'b0;
                  timeout_r    <= 1'b1;
               end
            end
            S_RESP: begin
               grant <= '0;
               ptr   <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign rsp_timeout = timeout_r;
   assign dbg_state   = state;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural multiplier of
// programmable latency (define MULT_ARB_TIMEOUT_EN to cover the watchdog).
module tb_mult_arbiter;
   import ode_ctrl_pkg::*;

   localparam int W  = 16;
   localparam int N  = 4;
   localparam int TO = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [N-1:0]     req = '0;
   logic [N*W-1:0]   op_a = '0;
   logic [N*W-1:0]   op_b = '0;
   logic [N-1:0]     grant, rsp_valid;
   logic [W-1:0]     rsp_data, mul_a, mul_b;
   logic             rsp_overflow, rsp_timeout, busy, mul_start;
   logic [W-1:0]     mul_out;
   logic             mul_overflow, mul_done;
   arb_state_t       dbg_state;

   int               n_total = 0;
   int               n_bad   = 0;
   int               model_lat = 8;
   logic             model_ovf = 1'b0;
   int               cyc_now = 0;
   int               pulse_cnt [N];
   logic [W-1:0]     exp_q [$];

   mult_arbiter #(
      .WORD_SIZE      (W),
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .op_a         (op_a),
      .op_b         (op_b),
      .grant        (grant),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .rsp_overflow (rsp_overflow),
      .rsp_timeout  (rsp_timeout),
      .busy         (busy),
      .mul_start    (mul_start),
      .mul_a        (mul_a),
      .mul_b        (mul_b),
      .mul_out      (mul_out),
      .mul_overflow (mul_overflow),
      .mul_done     (mul_done),
      .dbg_state    (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   always @(posedge clk) cyc_now <= cyc_now + 1;

   initial for (int i = 0; i < N; i++) pulse_cnt[i] = 0;
   always @(negedge clk)
      for (int i = 0; i < N; i++) if (rsp_valid[i]) pulse_cnt[i] = pulse_cnt[i] + 1;

   // ---------------- multiplier model (Q8.8, WAIT lasts model_lat cycles) ----------------
   logic [W-1:0]  m_a, m_b;
   int            m_cnt;
   logic [31:0]   m_prod;
   assign m_prod = 32'(m_a) * 32'(m_b);

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_cnt <= 0; m_a <= '0; m_b <= '0;
         mul_done <= 1'b0; mul_out <= '0; mul_overflow <= 1'b0;
      end else begin
         mul_done <= 1'b0;
         if (mul_start && model_lat != 0) begin
            m_cnt <= model_lat - 1;
            m_a   <= mul_a;
            m_b   <= mul_b;
         end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
               mul_done     <= 1'b1;
               mul_out      <= m_prod[23:8];
               mul_overflow <= model_ovf;
            end
         end
      end
   end

   // ---------------- scoreboard / driver tasks ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      op_a[i*W +: W] = a;
      op_b[i*W +: W] = b;
   endtask

   task automatic wait_start(input string tag);
      int c;
      c = 0;
      while (mul_start !== 1'b1 && c < 60) begin @(negedge clk); c++; end
      chk(tag, 32'(mul_start), 1);
   endtask

   task automatic wait_rsp(input string tag, output int c);
      c = 0;
      while (rsp_valid === '0 && c < 60) begin @(negedge clk); c++; end
      chk(tag, 32'(|rsp_valid), 1);
   endtask

   // ---------------- directed sequence ----------------
   logic [W-1:0] a_tab [N];
   logic [W-1:0] p_tab [N];
   int           base [N];
   int           c, rv, last_start;
   logic [W-1:0] g;

   initial begin
      a_tab = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
      p_tab = '{16'h0300, 16'h0600, 16'h0900, 16'h0C00};

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_mul_start", 32'(mul_start), 0);
      chk("rst_mul_a", 32'(mul_a), 0);
      chk("rst_rsp_data", 32'(rsp_data), 0);
      chk("rst_state", 32'(dbg_state), 0);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);

      // fairness: all four requesting, order 0,1,2,3,0,1,2,3
      model_lat = 3;
      for (int i = 0; i < N; i++) set_ops(i, a_tab[i], 16'h0300);
      for (int k = 0; k < 8; k++) exp_q.push_back(W'(1 << (k % N)));
      for (int i = 0; i < N; i++) base[i] = pulse_cnt[i];
      req = 4'b1111;
      last_start = 0;
      for (int k = 0; k < 8; k++) begin
         wait_start("fair_start");
         if (k > 0) chk("fair_spacing", 32'(cyc_now - last_start), 6);
         last_start = cyc_now;
         g = exp_q.pop_front();
         chk("fair_grant", 32'(grant), 32'(g));
         chk("fair_mul_a", 32'(mul_a), 32'(a_tab[k % N]));
         wait_rsp("fair_rsp", c);
         chk("fair_rsp_valid", 32'(rsp_valid), 32'(g));
         chk("fair_rsp_data", 32'(rsp_data), 32'(p_tab[k % N]));
         if (k == 7) req = '0;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < N; i++) chk("fair_pulses", 32'(pulse_cnt[i] - base[i]), 2);

      // single request, latency 8: rsp_valid on the 10th cycle
      model_lat = 8;
      set_ops(0, 16'h0100, 16'h0200);
      req = 4'b0001;
      @(negedge clk);
      c = 1;
      chk("single_mul_start", 32'(mul_start), 1);
      chk("single_grant", 32'(grant), 32'b0001);
      chk("single_mul_a", 32'(mul_a), 32'h0100);
      chk("single_mul_b", 32'(mul_b), 32'h0200);
      chk("single_busy", 32'(busy), 1);
      chk("single_state", 32'(dbg_state), 32'(S_START));
      while (rsp_valid === '0 && c < 40) begin @(negedge clk); c++; end
      chk("single_latency", 32'(c), 10);
      chk("single_rsp_valid", 32'(rsp_valid), 32'b0001);
      chk("single_rsp_data", 32'(rsp_data), 32'h0200);
      chk("single_overflow", 32'(rsp_overflow), 0);
      req = '0;
      @(negedge clk);
      chk("single_pulse_width", 32'(rsp_valid), 0);
      chk("single_grant_clear", 32'(grant), 0);
      chk("single_idle_busy", 32'(busy), 0);

      // pointer wrap: pointer at 1, req=1001 picks 3 then wraps to 0
      model_lat = 3;
      req = 4'b1001;
      wait_start("wrap_start3");
      chk("wrap_grant3", 32'(grant), 32'b1000);
      wait_rsp("wrap_rsp3", c);
      chk("wrap_rsp_data3", 32'(rsp_data), 32'h0C00);
      wait_start("wrap_start0");
      chk("wrap_grant0", 32'(grant), 32'b0001);
      wait_rsp("wrap_rsp0", c);
      chk("wrap_rsp_valid0", 32'(rsp_valid), 32'b0001);
      req = '0;
      @(negedge clk);

      // overflow passthrough, then cleared on the next operation
      model_ovf = 1'b1;
      set_ops(2, 16'h7F00, 16'h0400);
      req = 4'b0100;
      wait_start("ovf_start");
      wait_rsp("ovf_rsp", c);
      chk("ovf_rsp_valid", 32'(rsp_valid), 32'b0100);
      chk("ovf_rsp_data", 32'(rsp_data), 32'hFC00);
      chk("ovf_flag", 32'(rsp_overflow), 1);
      req = '0;
      @(negedge clk);
      model_ovf = 1'b0;
      set_ops(3, 16'h0080, 16'h0080);
      req = 4'b1000;
      wait_start("ovf2_start");
      chk("ovf2_grant", 32'(grant), 32'b1000);
      wait_rsp("ovf2_rsp", c);
      chk("ovf2_rsp_data", 32'(rsp_data), 32'h0040);
      chk("ovf2_flag", 32'(rsp_overflow), 0);
      req = '0;
      @(negedge clk);

      // dropped request still completes
      set_ops(1, 16'h0200, 16'h0180);
      req = 4'b0010;
      wait_start("drop_start");
      chk("drop_grant", 32'(grant), 32'b0010);
      req = '0;
      wait_rsp("drop_rsp", c);
      chk("drop_rsp_valid", 32'(rsp_valid), 32'b0010);
      chk("drop_rsp_data", 32'(rsp_data), 32'h0300);
      @(negedge clk);
      chk("drop_idle", 32'(busy), 0);

      // reset mid-WAIT with pointer at 2
      model_lat = 8;
      set_ops(2, 16'h0500, 16'h0200);
      req = 4'b0100;
      wait_start("rstw_start");
      chk("rstw_grant", 32'(grant), 32'b0100);
      repeat (3) @(negedge clk);
      chk("rstw_in_wait", 32'(dbg_state), 32'(S_WAIT));
      #2 rst = 1'b0;
      req = '0;
      #1;
      chk("rstw_grant0", 32'(grant), 0);
      chk("rstw_busy0", 32'(busy), 0);
      chk("rstw_mul_a0", 32'(mul_a), 0);
      chk("rstw_rsp_data0", 32'(rsp_data), 0);
      chk("rstw_state0", 32'(dbg_state), 0);
      rv = 0;
      repeat (3) begin @(negedge clk); if (rsp_valid !== '0) rv++; end
      rst = 1'b1;
      repeat (12) begin @(negedge clk); if (rsp_valid !== '0) rv++; end
      chk("rstw_no_rsp", 32'(rv), 0);
      set_ops(1, 16'h0300, 16'h0200);
      req = 4'b1010;
      wait_start("rstw_next_start");
      chk("rstw_next_grant", 32'(grant), 32'b0010);
      wait_rsp("rstw_next_rsp", c);
      chk("rstw_next_data", 32'(rsp_data), 32'h0600);
      req = '0;
      @(negedge clk);

`ifdef MULT_ARB_TIMEOUT_EN
      // watchdog: no done -> response 16 WAIT cycles later
      model_lat = 0;
      req = 4'b0001;
      wait_start("to_start");
      c = 0;
      while (rsp_valid === '0 && c < 60) begin @(negedge clk); c++; end
      chk("to_latency", 32'(c), 17);
      chk("to_rsp_valid", 32'(rsp_valid), 32'b0001);
      chk("to_flag", 32'(rsp_timeout), 1);
      chk("to_data", 32'(rsp_data), 0);
      chk("to_overflow", 32'(rsp_overflow), 0);
      req = '0;
      @(negedge clk);
      // done on the 16th WAIT cycle wins over the watchdog
      model_lat = 16;
      req = 4'b0001;
      wait_start("to2_start");
      c = 0;
      while (rsp_valid === '0 && c < 60) begin @(negedge clk); c++; end
      chk("to2_latency", 32'(c), 17);
      chk("to2_flag", 32'(rsp_timeout), 0);
      chk("to2_data", 32'(rsp_data), 32'h0200);
      req = '0;
      @(negedge clk);
`else
      chk("no_timeout_flag", 32'(rsp_timeout), 0);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer that shares one `multiplier_modified_booth` instance among up to `NUM_REQ` requesters in the ODE accelerator, such as the step module, the solver core and the error estimator. It latches the winning requester's operands and pulses the multiplier start. It then waits for the multiplier's done and returns the product, overflow flag and a completion pulse to that requester only.

## Interface
- `WORD_SIZE`, 16, operand/result width (fixed point, same format as the multiplier)
- `NUM_REQ`, 4, number of requesters, 2..8
- `TIMEOUT_CYCLES`, 64, watchdog limit in cycles (used only with the macro)

- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req`  in  NUM_REQ  per-requester request level
- `op_a`  in  NUM_REQ*WORD_SIZE  operand A, requester i in slice [i*WORD_SIZE +: WORD_SIZE]
- `op_b`  in  NUM_REQ*WORD_SIZE  operand B, same packing as `op_a`
- `grant`  out  NUM_REQ  one-hot owner of the multiplier, held from START through RESP
- `rsp_valid`  out  NUM_REQ  one-cycle completion pulse to the owner
- `rsp_data`  out  WORD_SIZE  product, valid while any `rsp_valid` bit is high
- `rsp_overflow`  out  1  multiplier overflow, qualified by `rsp_valid`
- `rsp_timeout`  out  1  watchdog fired, qualified by `rsp_valid`
- `busy`  out  1  high in every state except IDLE
- `mul_start`  out  1  one-cycle start pulse to the multiplier
- `mul_a`, `mul_b`  out  WORD_SIZE  latched operands, stable from START until the next grant
- `mul_out`  in  WORD_SIZE  multiplier product
- `mul_overflow`  in  1  multiplier overflow
- `mul_done`  in  1  multiplier completion

Reset values: every output is 0. The priority pointer is 0 and the state is IDLE.

## Operation
- **IDLE**:
  - If `req` is nonzero, pick the first asserted bit searching from the pointer upward, wrapping modulo NUM_REQ.
  - Register the picked requester's `op_a`/`op_b` into `mul_a`/`mul_b`.
  - Set `grant` one-hot and go to START.
  - If `req` is zero, stay in IDLE.
- **START**: assert `mul_start` for exactly this cycle, then go to WAIT.
- **WAIT**: on `mul_done`, register `mul_out` into `rsp_data` and `mul_overflow` into `rsp_overflow`, then go to RESP.
- **RESP**:
  - Assert `rsp_valid[owner]` for this cycle.
  - Set the pointer to (owner+1) mod NUM_REQ.
  - Clear `grant` on exit and go to IDLE.
- **Request rules**:
  - Requesters hold `req` and their operands until their `rsp_valid` pulse.
  - Operands are sampled only in IDLE, so later changes have no effect.
- **Dropped request**: if `req[owner]` falls mid-operation, the operation still completes and the `rsp_valid` pulse is still issued.
- **Spurious done**: `mul_done` outside WAIT is ignored.
- **Starvation bound**: with all requesters continuously asserting, each is served once per NUM_REQ operations.
- **Reset mid-operation**:
  - The FSM returns to IDLE immediately and the pointer returns to 0.
  - No `rsp_valid` is issued for the aborted operation.
  - The in-flight multiplier result is discarded, because the multiplier shares the same `rst`.

## Timing
- `req` sampled high in IDLE at edge 0:
  - edge 1: START, with `grant` and `mul_start` high.
  - edge 2: WAIT.
  - `mul_done` sampled at edge k: RESP at edge k+1, with `rsp_valid` high for one cycle.
- **Overhead**: 3 cycles on top of the multiplier latency (IDLE, START, RESP).
- **Back-to-back**: the minimum spacing between successive `mul_start` pulses is multiplier latency + 3 cycles.
- **Outputs**: all registered; there is no combinational path from `req` or `mul_done` to any output.

## Configuration
- **`MULT_ARB_TIMEOUT_EN` defined**:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without `mul_done`, the FSM goes to RESP with `rsp_timeout`=1, `rsp_data`=0 and `rsp_overflow`=0.
  - If `mul_done` and the timeout occur in the same cycle, `mul_done` wins and `rsp_timeout`=0.
- **`MULT_ARB_TIMEOUT_EN` undefined**: the counter is not built, `rsp_timeout` is tied to 0, and WAIT holds indefinitely.

## Structure
- **Shared package `ode_ctrl_pkg`** holds:
  - the state enum (IDLE, START, WAIT, RESP, 2 bits);
  - the default WORD_SIZE;
  - the `TIMEOUT_CYCLES` default.
- **Sub-module `rr_picker`** is natural: purely combinational, taking the `req` vector and the pointer and producing a one-hot grant plus the binary index.

## Test plan
- **Single request**: `req`=0001 with op_a=0x0100 and op_b=0x0200, multiplier model latency 8 → `mul_start` one cycle after `req`, `mul_a`/`mul_b`=0x0100/0x0200, `rsp_valid`=0001 at cycle 10, `rsp_data`=model product.
- **Fairness**: `req`=1111 held for 8 operations → grant order 0,1,2,3,0,1,2,3, and each `rsp_valid` bit pulses exactly twice.
- **Pointer wrap**: serve requester 3, then `req`=1001 → requester 0 granted next.
- **Overflow passthrough**: model asserts `mul_overflow`=1 → `rsp_overflow`=1 in the same cycle as `rsp_valid`, and 0 on the next operation.
- **Reset mid-WAIT**: drive `rst` low → all outputs 0 and `busy`=0 asynchronously, no `rsp_valid`, and the next request is granted to the lowest-index requester.
- **Timeout** (`MULT_ARB_TIMEOUT_EN` defined, TIMEOUT_CYCLES=16): model never asserts done → `rsp_valid` with `rsp_timeout`=1 and `rsp_data`=0 at 16 cycles after entering WAIT. Done arriving on the 16th cycle → `rsp_timeout`=0.
